// File: rtl/sr_latch_driver.sv
`default_nettype none
// ============================================================================
// Module   : sr_latch_driver
// Purpose  : Turns set/reset/sample commands into timed S/R pulses for a NOR
//            SR latch, then samples Q/Qn through a 2-flop synchronizer and
//            returns a checked response. Optional macro SR_DRV_FORBIDDEN_EN
//            lets cmd 11 drive S and R together for race characterisation.
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch_driver #(
    parameter int PULSE_W = 2,
    parameter int SETTLE  = 3
) (
    input  logic       in_clk,
    input  logic       in_rst_n,
    input  logic       in_cmd_valid,
    input  logic [1:0] in_cmd,
    output logic       out_cmd_ready,
    output logic       out_set,
    output logic       out_reset,
    input  logic       in_q,
    input  logic       in_qn,
    output logic       out_rsp_valid,
    input  logic       in_rsp_ready,
    output logic       out_rsp_q,
    output logic       out_rsp_err,
    output logic       out_busy
);

    localparam int CNT_MAX = (PULSE_W > SETTLE) ? PULSE_W : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] c_PULSE_LOAD  = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] c_SETTLE_LOAD = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_cmd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_set;
    logic             r_reset;
    logic             r_rspValid;
    logic             r_rspQ;
    logic             r_rspErr;
    logic [1:0]       r_qSync;
    logic [1:0]       r_qnSync;
    logic             w_qS;
    logic             w_qnS;
    logic             w_capErr;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_qSync  <= 2'b00;
            r_qnSync <= 2'b00;
        end else begin
            r_qSync  <= {r_qSync[0], in_q};
            r_qnSync <= {r_qnSync[0], in_qn};
        end
    end

    assign w_qS  = r_qSync[1];
    assign w_qnS = r_qnSync[1];

    // Equal Q/Qn means the latch is not in a valid stored state.
    assign w_capErr = (w_qS == w_qnS)
                    | ((r_cmd == 2'b01) & ~w_qS)
                    | ((r_cmd == 2'b10) &  w_qS)
                    |  (r_cmd == 2'b11);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state    <= S_IDLE;
            r_cmd      <= 2'b00;
            r_cnt      <= '0;
            r_set      <= 1'b0;
            r_reset    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspQ     <= 1'b0;
            r_rspErr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_cmd_valid) begin
                        r_cmd <= in_cmd;
                        case (in_cmd)
                            2'b01: begin
                                r_set   <= 1'b1;
                                r_cnt   <= c_PULSE_LOAD;
                                r_state <= S_PULSE;
                            end
                            2'b10: begin
                                r_reset <= 1'b1;
                                r_cnt   <= c_PULSE_LOAD;
                                r_state <= S_PULSE;
                            end
                            2'b00: begin
                                r_cnt   <= c_SETTLE_LOAD;
                                r_state <= S_SETTLE;
                            end
                            default: begin
`ifdef SR_DRV_FORBIDDEN_EN
                                r_set   <= 1'b1;
                                r_reset <= 1'b1;
                                r_cnt   <= c_PULSE_LOAD;
                                r_state <= S_PULSE;
`else
                                r_state <= S_RESP;
`endif
                            end
                        endcase
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_set   <= 1'b0;
                        r_reset <= 1'b0;
                        r_cnt   <= c_SETTLE_LOAD;
                        r_state <= S_SETTLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == '0) begin
                        r_rspValid <= 1'b1;
                        r_rspQ     <= w_qS;
                        r_rspErr   <= w_capErr;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    // A direct IDLE->RESP entry arrives without a response yet.
                    if (!r_rspValid) begin
                        r_rspValid <= 1'b1;
                        r_rspQ     <= w_qS;
                        r_rspErr   <= w_capErr;
                    end else if (in_rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_cmd_ready = (r_state == S_IDLE);
    assign out_busy      = (r_state != S_IDLE);
    assign out_set       = r_set;
    assign out_reset     = r_reset;
    assign out_rsp_valid = r_rspValid;
    assign out_rsp_q     = r_rspQ;
    assign out_rsp_err   = r_rspErr;

endmodule
`default_nettype wire
